// File: rtl/procyon_cdb_arbiter.sv
// procyon_cdb_arbiter
//
// Shares the single Common Data Bus among several functional units. Each unit
// pushes completed results into its own small FIFO. Every cycle a round-robin
// arbiter picks one non-empty FIFO head and broadcasts it through a registered
// CDB output. A full FIFO raises that unit's stall, and a flush throws away
// everything still waiting.
//
// Ports:
//   clk             - the only clock
//   rst             - synchronous active-high reset
//   i_flush         - pipeline flush; drops all queued and incoming results
//   i_req_en        - per-requester result valid
//   i_req_redirect  - per-requester redirect flag
//   i_req_data      - per-requester result data
//   i_req_tag       - per-requester ROB tag
//   o_req_stall     - per-requester backpressure (FIFO full)
//   o_cdb_en        - CDB broadcast valid
//   o_cdb_redirect  - CDB redirect flag
//   o_cdb_data      - CDB data (holds its last value when idle)
//   o_cdb_tag       - CDB ROB tag (holds its last value when idle)

module procyon_cdb_arbiter #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_CDB_REQ_CNT   = 3,
  parameter int OPTN_CDB_BUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_flush,
  input  logic [OPTN_CDB_REQ_CNT-1:0]   i_req_en,
  input  logic [OPTN_CDB_REQ_CNT-1:0]   i_req_redirect,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_req_data [0:OPTN_CDB_REQ_CNT-1],
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_req_tag  [0:OPTN_CDB_REQ_CNT-1],
  output logic [OPTN_CDB_REQ_CNT-1:0]   o_req_stall,
  output logic                          o_cdb_en,
  output logic                          o_cdb_redirect,
  output logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag
);

  localparam int PtrWidth   = $clog2(OPTN_CDB_BUF_DEPTH);
  localparam int CountWidth = PtrWidth + 1;
  localparam int RrWidth    = $clog2(OPTN_CDB_REQ_CNT);

  localparam logic [CountWidth-1:0] FullCount    = CountWidth'(OPTN_CDB_BUF_DEPTH);
  localparam logic [RrWidth-1:0]    RrResetValue = RrWidth'(OPTN_CDB_REQ_CNT - 1);

  // FIFO storage, one small circular buffer per requester
  logic [OPTN_DATA_WIDTH-1:0]    bufData_q     [0:OPTN_CDB_REQ_CNT-1][0:OPTN_CDB_BUF_DEPTH-1];
  logic [OPTN_ROB_IDX_WIDTH-1:0] bufTag_q      [0:OPTN_CDB_REQ_CNT-1][0:OPTN_CDB_BUF_DEPTH-1];
  logic                          bufRedirect_q [0:OPTN_CDB_REQ_CNT-1][0:OPTN_CDB_BUF_DEPTH-1];

  logic [PtrWidth-1:0]   rdPtr_q [0:OPTN_CDB_REQ_CNT-1];
  logic [PtrWidth-1:0]   rdPtr_d [0:OPTN_CDB_REQ_CNT-1];
  logic [PtrWidth-1:0]   wrPtr_q [0:OPTN_CDB_REQ_CNT-1];
  logic [PtrWidth-1:0]   wrPtr_d [0:OPTN_CDB_REQ_CNT-1];
  logic [CountWidth-1:0] count_q [0:OPTN_CDB_REQ_CNT-1];
  logic [CountWidth-1:0] count_d [0:OPTN_CDB_REQ_CNT-1];

  logic [RrWidth-1:0] rrPtr_q;
  logic [RrWidth-1:0] rrPtr_d;

  logic                          grantValid;
  logic [RrWidth-1:0]            grantIdx;
  logic [OPTN_CDB_REQ_CNT-1:0]   enqueue;
  logic [OPTN_CDB_REQ_CNT-1:0]   dequeue;
  logic [OPTN_DATA_WIDTH-1:0]    headData;
  logic [OPTN_ROB_IDX_WIDTH-1:0] headTag;
  logic                          headRedirect;

  // Requester index reached by stepping 'offset' places past 'base', wrapping
  // at the requester count (which need not be a power of two).
  function automatic logic [RrWidth-1:0] rrIndex(input logic [RrWidth-1:0] base,
                                                 input int offset);
    return RrWidth'((int'(base) + offset) % OPTN_CDB_REQ_CNT);
  endfunction

  // A requester is stalled exactly when its FIFO is full. This depends only on
  // registered counts so requesters never see a combinational loop back from
  // their own request lines.
  always_comb begin
    o_req_stall = '0;
    for (int i = 0; i < OPTN_CDB_REQ_CNT; i++) begin
      o_req_stall[i] = (count_q[i] == FullCount);
    end
  end

  // Round-robin search starting one past the last winner. The first non-empty
  // FIFO found wins; because the search starts after the previous grant, every
  // busy requester gets a turn before any requester is served twice.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = rrPtr_q;
    for (int k = 1; k <= OPTN_CDB_REQ_CNT; k++) begin
      if (!grantValid && (count_q[rrIndex(rrPtr_q, k)] != '0)) begin
        grantValid = 1'b1;
        grantIdx   = rrIndex(rrPtr_q, k);
      end
    end
  end

  // Head fields of the winning FIFO, which feed the CDB output register.
  always_comb begin
    headData     = bufData_q[grantIdx][rdPtr_q[grantIdx]];
    headTag      = bufTag_q[grantIdx][rdPtr_q[grantIdx]];
    headRedirect = bufRedirect_q[grantIdx][rdPtr_q[grantIdx]];
  end

  // Per-FIFO push/pop decisions. A stalled requester's result is dropped, and
  // a flush blocks all pushes. The winner's head is popped in the same cycle
  // it is chosen, so a full FIFO still drains while stalled.
  always_comb begin
    enqueue = '0;
    dequeue = '0;
    for (int i = 0; i < OPTN_CDB_REQ_CNT; i++) begin
      enqueue[i] = i_req_en[i] & ~o_req_stall[i] & ~i_flush;
      dequeue[i] = grantValid && (grantIdx == RrWidth'(i));
    end
  end

  // Next pointer and count values. Push and pop on the same FIFO in one cycle
  // leave the count unchanged, giving full throughput. A flush empties every
  // FIFO but leaves the round-robin pointer alone so fairness carries across.
  always_comb begin
    for (int i = 0; i < OPTN_CDB_REQ_CNT; i++) begin
      rdPtr_d[i] = rdPtr_q[i];
      wrPtr_d[i] = wrPtr_q[i];
      count_d[i] = count_q[i];
      if (i_flush) begin
        rdPtr_d[i] = '0;
        wrPtr_d[i] = '0;
        count_d[i] = '0;
      end else begin
        wrPtr_d[i] = wrPtr_q[i] + PtrWidth'(enqueue[i]);
        rdPtr_d[i] = rdPtr_q[i] + PtrWidth'(dequeue[i]);
        count_d[i] = count_q[i] + CountWidth'(enqueue[i]) - CountWidth'(dequeue[i]);
      end
    end
    rrPtr_d = (grantValid && !i_flush) ? grantIdx : rrPtr_q;
  end

  // FIFO bookkeeping registers. Reset empties all FIFOs and parks the
  // round-robin pointer on the last requester so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OPTN_CDB_REQ_CNT; i++) begin
        rdPtr_q[i] <= '0;
        wrPtr_q[i] <= '0;
        count_q[i] <= '0;
      end
      rrPtr_q <= RrResetValue;
    end else begin
      for (int i = 0; i < OPTN_CDB_REQ_CNT; i++) begin
        rdPtr_q[i] <= rdPtr_d[i];
        wrPtr_q[i] <= wrPtr_d[i];
        count_q[i] <= count_d[i];
      end
      rrPtr_q <= rrPtr_d;
    end
  end

  // FIFO payload storage. It needs no reset because the counts decide which
  // slots hold live entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OPTN_CDB_REQ_CNT; i++) begin
      if (enqueue[i]) begin
        bufData_q[i][wrPtr_q[i]]     <= i_req_data[i];
        bufTag_q[i][wrPtr_q[i]]      <= i_req_tag[i];
        bufRedirect_q[i][wrPtr_q[i]] <= i_req_redirect[i];
      end
    end
  end

  // CDB output register. Valid and redirect are suppressed by a flush. Data
  // and tag only load on a grant so consumers see stable values while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cdb_en       <= 1'b0;
      o_cdb_redirect <= 1'b0;
      o_cdb_data     <= '0;
      o_cdb_tag      <= '0;
    end else begin
      o_cdb_en       <= grantValid & ~i_flush;
      o_cdb_redirect <= grantValid & ~i_flush & headRedirect;
      if (grantValid) begin
        o_cdb_data <= headData;
        o_cdb_tag  <= headTag;
      end
    end
  end

endmodule

// File: tb/tb_procyon_cdb_arbiter.sv
// tb_procyon_cdb_arbiter
//
// Self-checking bench for procyon_cdb_arbiter with three requesters and
// two-entry FIFOs. A queue-based reference model tracks what must be on the
// CDB every cycle; directed sequences add hand-computed expectations.

module tb_procyon_cdb_arbiter;

  localparam int NumReq = 3;
  localparam int Depth  = 2;

  typedef struct packed {
    logic        redirect;
    logic [31:0] data;
    logic [4:0]  tag;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  reqEn = '0;
  logic [2:0]  reqRedirect = '0;
  logic [31:0] reqData [0:NumReq-1];
  logic [4:0]  reqTag  [0:NumReq-1];
  logic [2:0]  o_req_stall;
  logic        o_cdb_en;
  logic        o_cdb_redirect;
  logic [31:0] o_cdb_data;
  logic [4:0]  o_cdb_tag;

  int total = 0;
  int bad = 0;
  logic checkOn = 1'b0;
  logic [31:0] dataBase = 32'hD000_0000;
  logic [2:0] seq [0:NumReq-1];

  // Reference model state
  entry_t      modelQ [NumReq][$];
  int          modelPtr = NumReq - 1;
  logic        modelEn = 1'b0;
  logic        modelRed = 1'b0;
  logic [31:0] modelData = '0;
  logic [4:0]  modelTag = '0;

  procyon_cdb_arbiter #(
    .OPTN_DATA_WIDTH(32),
    .OPTN_ROB_IDX_WIDTH(5),
    .OPTN_CDB_REQ_CNT(NumReq),
    .OPTN_CDB_BUF_DEPTH(Depth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_flush(flush),
    .i_req_en(reqEn),
    .i_req_redirect(reqRedirect),
    .i_req_data(reqData),
    .i_req_tag(reqTag),
    .o_req_stall(o_req_stall),
    .o_cdb_en(o_cdb_en),
    .o_cdb_redirect(o_cdb_redirect),
    .o_cdb_data(o_cdb_data),
    .o_cdb_tag(o_cdb_tag)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends with a report
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison helper; every check in the bench goes through here
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue per requester, advanced once per clock edge
  always @(posedge clk) begin
    logic [2:0] stallPre;
    int g;
    entry_t h;
    entry_t e;
    if (rst) begin
      for (int k = 0; k < NumReq; k++) modelQ[k].delete();
      modelPtr  = NumReq - 1;
      modelEn   = 1'b0;
      modelRed  = 1'b0;
      modelData = '0;
      modelTag  = '0;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        stallPre[k] = (modelQ[k].size() == Depth);
        assert (!(reqEn[k] && stallPre[k])) else begin
          bad++;
          $display("[TB] FAIL protocolStall: requester %0d presented while stalled", k);
        end
      end
      g = -1;
      for (int s = 1; s <= NumReq; s++) begin
        int idx;
        idx = (modelPtr + s) % NumReq;
        if (g < 0 && modelQ[idx].size() > 0) g = idx;
      end
      modelEn  = (g >= 0) && !flush;
      modelRed = 1'b0;
      if (g >= 0) begin
        h = modelQ[g][0];
        modelData = h.data;
        modelTag  = h.tag;
        modelRed  = modelEn && h.redirect;
      end
      if (flush) begin
        for (int k = 0; k < NumReq; k++) modelQ[k].delete();
      end else begin
        if (g >= 0) begin
          void'(modelQ[g].pop_front());
          modelPtr = g;
        end
        for (int k = 0; k < NumReq; k++) begin
          if (reqEn[k] && !stallPre[k]) begin
            e.redirect = reqRedirect[k];
            e.data     = reqData[k];
            e.tag      = reqTag[k];
            modelQ[k].push_back(e);
          end
        end
      end
    end
  end

  // Every cycle, compare the DUT against the model just after the clock edge
  always @(posedge clk) begin
    logic [2:0] expStall;
    #1;
    if (checkOn) begin
      for (int k = 0; k < NumReq; k++) expStall[k] = (modelQ[k].size() == Depth);
      cmp("cmpEn", 32'(o_cdb_en), 32'(modelEn));
      cmp("cmpRedirect", 32'(o_cdb_redirect), 32'(modelRed));
      cmp("cmpData", o_cdb_data, modelData);
      cmp("cmpTag", 32'(o_cdb_tag), 32'(modelTag));
      cmp("cmpStall", 32'(o_req_stall), 32'(expStall));
    end
  end

  // Hold reset for one edge, returning just after that edge
  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    reqEn = '0;
    reqRedirect = '0;
    for (int k = 0; k < NumReq; k++) seq[k] = '0;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests, returning just after the capturing edge
  task automatic applyStimulus(input logic [2:0] en, input logic [2:0] red,
                               input logic [4:0] t0, input logic [4:0] t1,
                               input logic [4:0] t2);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    reqEn = en;
    reqRedirect = red;
    reqTag[0] = t0;
    reqTag[1] = t1;
    reqTag[2] = t2;
    for (int k = 0; k < NumReq; k++) reqData[k] = dataBase + 32'(reqTag[k]);
    @(posedge clk);
    #1;
  endtask

  // Every requester sends whenever it is not stalled; tags carry the
  // requester number in the top two bits and a sequence count below
  task automatic driveAllSend(input logic doFlush, input logic doReset);
    @(negedge clk);
    rst = doReset;
    flush = doFlush;
    reqRedirect = '0;
    for (int k = 0; k < NumReq; k++) begin
      reqEn[k]   = !o_req_stall[k];
      reqTag[k]  = {2'(k), seq[k]};
      reqData[k] = dataBase + 32'(reqTag[k]);
    end
    @(posedge clk);
    #1;
    if (!doFlush && !doReset) begin
      for (int k = 0; k < NumReq; k++) if (reqEn[k]) seq[k] = seq[k] + 3'd1;
    end
  endtask

  // Hand-computed expectation for the outputs visible right now
  task automatic checkOutput(input string name, input logic expEn, input logic expRed,
                             input logic [4:0] expTag, input logic [31:0] expData,
                             input logic [2:0] expStall);
    cmp({name, ".en"}, 32'(o_cdb_en), 32'(expEn));
    cmp({name, ".redirect"}, 32'(o_cdb_redirect), 32'(expRed));
    cmp({name, ".tag"}, 32'(o_cdb_tag), 32'(expTag));
    cmp({name, ".data"}, o_cdb_data, expData);
    cmp({name, ".stall"}, 32'(o_req_stall), 32'(expStall));
  endtask

  initial begin
    logic [2:0] stallSeen;
    int enCount;
    int grantCount [0:NumReq-1];
    logic found;

    for (int k = 0; k < NumReq; k++) begin
      reqData[k] = '0;
      reqTag[k]  = '0;
      seq[k]     = '0;
    end

    // Reset state, then requester 0 alone sends tags 1, 2, 3
    resetDut();
    checkOn = 1'b1;
    checkOutput("t1Reset", 1'b0, 1'b0, 5'd0, 32'h0, 3'b000);
    applyStimulus(3'b001, 3'b000, 5'd1, 5'd0, 5'd0);
    checkOutput("t1c0", 1'b0, 1'b0, 5'd0, 32'h0, 3'b000);
    applyStimulus(3'b001, 3'b000, 5'd2, 5'd0, 5'd0);
    checkOutput("t1c1", 1'b1, 1'b0, 5'd1, 32'hD000_0001, 3'b000);
    applyStimulus(3'b001, 3'b000, 5'd3, 5'd0, 5'd0);
    checkOutput("t1c2", 1'b1, 1'b0, 5'd2, 32'hD000_0002, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t1c3", 1'b1, 1'b0, 5'd3, 32'hD000_0003, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t1c4", 1'b0, 1'b0, 5'd3, 32'hD000_0003, 3'b000);

    // All three request together twice; order follows the rotating pointer
    resetDut();
    applyStimulus(3'b111, 3'b000, 5'd10, 5'd20, 5'd30);
    checkOutput("t2a0", 1'b0, 1'b0, 5'd0, 32'h0, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t2a1", 1'b1, 1'b0, 5'd10, 32'hD000_000A, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t2a2", 1'b1, 1'b0, 5'd20, 32'hD000_0014, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t2a3", 1'b1, 1'b0, 5'd30, 32'hD000_001E, 3'b000);
    applyStimulus(3'b111, 3'b000, 5'd11, 5'd21, 5'd31);
    checkOutput("t2b0", 1'b0, 1'b0, 5'd30, 32'hD000_001E, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t2b1", 1'b1, 1'b0, 5'd11, 32'hD000_000B, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t2b2", 1'b1, 1'b0, 5'd21, 32'hD000_0015, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t2b3", 1'b1, 1'b0, 5'd31, 32'hD000_001F, 3'b000);

    // Redirect result from requester 1; data and tag hold once idle
    dataBase = 32'hDEAD_BEEA;
    applyStimulus(3'b010, 3'b010, 5'd0, 5'd5, 5'd0);
    checkOutput("t4c0", 1'b0, 1'b0, 5'd31, 32'hD000_001F, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t4c1", 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t4c2", 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF, 3'b000);
    dataBase = 32'hD000_0000;

    // Saturating traffic: stalls appear early, then strict rotation
    resetDut();
    stallSeen = '0;
    enCount = 0;
    for (int k = 0; k < NumReq; k++) grantCount[k] = 0;
    for (int c = 0; c < 16; c++) begin
      driveAllSend(1'b0, 1'b0);
      if (c < 4) stallSeen = stallSeen | o_req_stall;
      if (c >= 4 && o_cdb_en) begin
        enCount++;
        if (o_cdb_tag[4:3] < 2'(NumReq)) grantCount[o_cdb_tag[4:3]]++;
      end
    end
    cmp("t3StallSeen", 32'(stallSeen), 32'h7);
    cmp("t3Throughput", 32'(enCount), 32'd12);
    cmp("t3Share0", 32'(grantCount[0]), 32'd4);
    cmp("t3Share1", 32'(grantCount[1]), 32'd4);
    cmp("t3Share2", 32'(grantCount[2]), 32'd4);

    // Reset in the middle of saturating traffic
    driveAllSend(1'b0, 1'b1);
    checkOutput("t6Reset", 1'b0, 1'b0, 5'd0, 32'h0, 3'b000);
    applyStimulus(3'b111, 3'b000, 5'd3, 5'd13, 5'd23);
    checkOutput("t6c0", 1'b0, 1'b0, 5'd0, 32'h0, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t6c1", 1'b1, 1'b0, 5'd3, 32'hD000_0003, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t6c2", 1'b1, 1'b0, 5'd13, 32'hD000_000D, 3'b000);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOutput("t6c3", 1'b1, 1'b0, 5'd23, 32'hD000_0017, 3'b000);

    // Fill requester 2, then flush alongside new requests
    resetDut();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      driveAllSend(1'b0, 1'b0);
      if (o_req_stall[2]) found = 1'b1;
    end
    cmp("t5Fill", 32'(found), 32'd1);
    driveAllSend(1'b1, 1'b0);
    cmp("t5FlushEn", 32'(o_cdb_en), 32'd0);
    cmp("t5FlushStall", 32'(o_req_stall), 32'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
      cmp("t5AfterFlushEn", 32'(o_cdb_en), 32'd0);
    end
    applyStimulus(3'b100, 3'b000, 5'd0, 5'd0, 5'd9);
    cmp("t5RecoverIdle", 32'(o_cdb_en), 32'd0);
    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    cmp("t5RecoverEn", 32'(o_cdb_en), 32'd1);
    cmp("t5RecoverTag", 32'(o_cdb_tag), 32'd9);

    applyStimulus(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/procyon_cdb_arbiter.md
Name: procyon_cdb_arbiter

Overview:
Shares the single Common Data Bus among OPTN_CDB_REQ_CNT functional units, for example the integer execution unit, the LSU and the multiply/divide unit.
- Each unit pushes its completed result (data, ROB tag, redirect flag) into a private FIFO.
- A round-robin arbiter picks one FIFO head per cycle and broadcasts it on a registered CDB output.
- Per-requester stall provides backpressure when a FIFO fills.
- Flush discards all pending results.

Parameters:
OPTN_DATA_WIDTH, 32, CDB data width.
OPTN_ROB_IDX_WIDTH, 5, ROB tag width.
OPTN_CDB_REQ_CNT, 3, number of requesters (range 2..8).
OPTN_CDB_BUF_DEPTH, 2, entries per requester FIFO (power of 2, at least 2).

Ports:
clk  in  1  clock; the only clock.
rst  in  1  reset; synchronous, active-high.
i_flush  in  1  pipeline flush.
i_req_en  in  OPTN_CDB_REQ_CNT  per-requester result valid.
i_req_redirect  in  OPTN_CDB_REQ_CNT  per-requester redirect flag.
i_req_data  in  [0:OPTN_CDB_REQ_CNT-1] x OPTN_DATA_WIDTH  per-requester result data.
i_req_tag  in  [0:OPTN_CDB_REQ_CNT-1] x OPTN_ROB_IDX_WIDTH  per-requester ROB tag.
o_req_stall  out  OPTN_CDB_REQ_CNT  per-requester backpressure.
o_cdb_en  out  1  CDB broadcast valid.
o_cdb_redirect  out  1  CDB redirect.
o_cdb_data  out  OPTN_DATA_WIDTH  CDB data.
o_cdb_tag  out  OPTN_ROB_IDX_WIDTH  CDB ROB tag.

Behaviour:
- Reset (rst high at a clock edge):
  - All FIFOs empty.
  - Round-robin pointer = OPTN_CDB_REQ_CNT-1, so requester 0 has highest priority first.
  - o_cdb_en, o_cdb_redirect, o_cdb_data and o_cdb_tag all 0.
  - o_req_stall all 0.
  - rst overrides i_flush and all requests.
- Stall: o_req_stall[i] = (count_i == OPTN_CDB_BUF_DEPTH). It is decoded from registered state only; there is no combinational path from any input.
- Enqueue: accepted when i_req_en[i] & ~o_req_stall[i] & ~i_flush.
  - A request presented while stalled is dropped. This is a requester protocol violation and should be flagged by a bench assertion.
- Arbitration: combinational over the heads of non-empty FIFOs, from registered state only.
  - Priority order is ptr+1, ptr+2, ... mod OPTN_CDB_REQ_CNT.
  - On a grant, ptr <= granted index. With no grant, ptr holds.
  - The granted head is dequeued in the same cycle.
- Same cycle enqueue and dequeue on one FIFO: count unchanged, full throughput.
  - At full, no enqueue is possible because stall is high; a dequeue still occurs.
- Output register, updated every cycle:
  - o_cdb_en <= grant_valid & ~i_flush.
  - o_cdb_redirect <= grant_valid & ~i_flush & head.redirect.
  - o_cdb_data / o_cdb_tag <= head fields on a grant; otherwise they hold their previous value.
- Latency: a request accepted in cycle N is broadcast no earlier than cycle N+2 (enqueue at edge N, arbitrate in N+1, output register at edge N+1).
  - Sustained throughput is one result per cycle in aggregate.
- Flush (i_flush high in cycle N):
  - All FIFO counts and pointers are cleared at edge N.
  - Requests presented in cycle N are dropped.
  - o_cdb_en = 0 in cycle N+1.
  - o_req_stall = 0 from cycle N+1.
  - The round-robin pointer is preserved.
- FIFO read/write pointers wrap modulo OPTN_CDB_BUF_DEPTH. Count is log2(OPTN_CDB_BUF_DEPTH)+1 bits wide.
- Per-requester ordering is preserved. There is no ordering guarantee across requesters.

Test Plan:
1. Reset, then requester 0 alone sends tags 1, 2, 3 on consecutive cycles from cycle 0 -> o_cdb_en high in cycles 2, 3, 4 with tags 1, 2, 3; o_req_stall[0] never asserts.
2. All 3 requesters send one request in cycle 0 with tags 10, 20, 30 -> broadcasts in cycles 2, 3, 4 in order 10, 20, 30. Repeat with tags 11, 21, 31 -> order 11, 21, 31, confirming rotation from ptr = 2.
3. All 3 requesters send every cycle, honouring stall -> each requester gets exactly 1 of every 3 broadcasts. The FIFOs fill and each o_req_stall asserts by cycle 2. No accepted tag is lost or duplicated.
4. Requester 1 sends tag 5 with redirect = 1 and data 0xDEADBEEF -> in cycle 2, o_cdb_redirect = 1, data = 0xDEADBEEF, tag = 5. The next idle cycle shows en = 0 and redirect = 0, with data still 0xDEADBEEF.
5. Fill requester 2's FIFO, then assert i_flush together with a new request -> o_cdb_en = 0 and o_req_stall = 0 in the following cycle; no pre-flush tag is ever broadcast.
6. Assert rst in the middle of test 3 -> all outputs are 0 the next cycle, and the next single request is broadcast 2 cycles after it is presented, with requester 0 prioritised first.
